// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: tracks outstanding branch checkpoints in program
// order and sequences mispredict recovery and front-end flush.
package ooop_types;
  localparam int ROB_W = 6;
endpackage

module checkpoint_ctrl #(
  parameter int ROB_W        = ooop_types::ROB_W,
  parameter int MAX_BR       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rename_valid_i,
  input  logic                         rename_is_branch_i,
  input  logic [ROB_W-1:0]             rename_rob_tag_i,
  output logic                         rename_ready_o,
  output logic                         checkpoint_take_o,
  output logic [ROB_W-1:0]             checkpoint_tag_o,
  input  logic                         resolve_valid_i,
  input  logic [ROB_W-1:0]             resolve_tag_i,
  input  logic                         resolve_mispredict_i,
  output logic                         recover_o,
  output logic [ROB_W-1:0]             recover_tag_o,
  output logic                         flush_o,
  output logic [$clog2(MAX_BR):0]      br_count_o,
  output logic                         stale_resolve_o
);

  localparam int PW = $clog2(MAX_BR);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES < 2) ? 1
                    : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECOVER,
    FLUSH
  } state_t;

  state_t            state_q, state_n;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_n;
  logic [ROB_W-1:0]  tag_q [MAX_BR];
  logic [MAX_BR-1:0] res_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic              recover_q, flush_q, stale_q;
  logic [ROB_W-1:0]  rtag_q;

  logic          idle, hit, acc, mis_acc;
  logic          stale, pop, take;
  logic [PW-1:0] hit_idx, hit_dist;

  // An entry is active when its distance from head is below count.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < MAX_BR; i++) begin
      if (!hit
          && ({1'b0, PW'(i) - head_q} < count_q)
          && tag_q[i] == resolve_tag_i) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign idle    = state_q == IDLE;
  assign acc     = resolve_valid_i & idle & hit;
  assign mis_acc = acc & resolve_mispredict_i;
  assign stale   = resolve_valid_i & idle & ~hit;

  assign rename_ready_o = idle & ~mis_acc
    & ((count_q < CW'(MAX_BR)) | ~rename_is_branch_i);

  assign take = rename_valid_i & rename_is_branch_i
              & rename_ready_o;

  assign checkpoint_take_o = take;
  assign checkpoint_tag_o  = rename_rob_tag_i;

  assign hit_dist = hit_idx - head_q;

  // A mispredict on the head itself discards it, so no pop then.
  assign pop = (count_q != '0) & res_q[head_q]
             & ~(mis_acc & (hit_dist == '0));

  always_comb begin
    state_n     = state_q;
    flush_cnt_n = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mis_acc) begin
          state_n     = RECOVER;
          flush_cnt_n = FW'(FLUSH_CYCLES);
        end
      end
      RECOVER: state_n = FLUSH;
      FLUSH: begin
        flush_cnt_n = flush_cnt_q - FW'(1);
        if (flush_cnt_q == FW'(1))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      res_q       <= '0;
      recover_q   <= 1'b0;
      rtag_q      <= '0;
      flush_q     <= 1'b0;
      stale_q     <= 1'b0;
      for (int i = 0; i < MAX_BR; i++)
        tag_q[i] <= '0;
    end else begin
      state_q     <= state_n;
      flush_cnt_q <= flush_cnt_n;
      recover_q   <= mis_acc;
      if (mis_acc)
        rtag_q <= resolve_tag_i;
      flush_q <= state_n != IDLE;
      stale_q <= stale;
      if (pop)
        res_q[head_q] <= 1'b0;
      if (acc & ~resolve_mispredict_i)
        res_q[hit_idx] <= 1'b1;
      if (take) begin
        tag_q[tail_q] <= rename_rob_tag_i;
        res_q[tail_q] <= 1'b0;
      end
      head_q <= head_q + PW'(pop);
      if (mis_acc) begin
        tail_q  <= hit_idx;
        count_q <= {1'b0, hit_dist} - CW'(pop);
      end else begin
        tail_q  <= tail_q + PW'(take);
        count_q <= count_q + CW'(take) - CW'(pop);
      end
    end
  end

  assign recover_o       = recover_q;
  assign recover_tag_o   = rtag_q;
  assign flush_o         = flush_q;
  assign br_count_o      = count_q;
  assign stale_resolve_o = stale_q;

endmodule
